// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the execute-stage divide sequencer.
// Optional result cache is enabled by defining DIV_RESULT_CACHE_EN.
package div_seq_ctrl_pkg;

  localparam int XLEN_D = 32;

  localparam int F3_UNS = 0;
  localparam int F3_REM = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SIGN,
    S_DONE
  } div_state_t;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Handshake and data bundle between the execute stage and the divide sequencer.
// Master is the pipeline side, slave is the sequencer.
interface div_seq_ctrl_if
  import div_seq_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_D
) ();

  logic            Valid_In;
  logic            IDiv;
  logic [1:0]      Funct3;
  logic [XLEN-1:0] Op_A;
  logic [XLEN-1:0] Op_B;
  logic            Flush;
  logic            Stall;
  logic            Busy;
  logic            Div_Valid;
  logic [XLEN-1:0] Div_Result;

  modport master (
    output Valid_In,
    output IDiv,
    output Funct3,
    output Op_A,
    output Op_B,
    output Flush,
    input  Stall,
    input  Busy,
    input  Div_Valid,
    input  Div_Result
  );

  modport slave (
    input  Valid_In,
    input  IDiv,
    input  Funct3,
    input  Op_A,
    input  Op_B,
    input  Flush,
    output Stall,
    output Busy,
    output Div_Valid,
    output Div_Result
  );

endinterface

// File: rtl/div_iter_step.sv
// One radix-2 restoring divide step on magnitudes.
// Shifts {rem,quo} left, trial-subtracts the divisor, sets the new quotient bit.
module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_dvs,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0]   w_sh;
  logic [XLEN-1:0] w_sub;
  logic            w_ge;

  assign w_sh  = {i_rem, i_quo[XLEN-1]};
  assign w_ge  = w_sh >= {1'b0, i_dvs};
  // The kept difference is always below the divisor, so XLEN bits suffice.
  assign w_sub = w_sh[XLEN-1:0] - i_dvs;

  always_comb begin
    o_rem = w_sh[XLEN-1:0];
    o_quo = {i_quo[XLEN-2:0], 1'b0};
    if (w_ge) begin
      o_rem = w_sub;
      o_quo = {i_quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer with pipeline stall ownership.
// Define DIV_RESULT_CACHE_EN to reuse the last completed operand pair.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input logic          CLK,
  input logic          RST,
  div_seq_ctrl_if.slave bus
);

  div_state_t      r_state;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic            r_f3_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_busy;
  logic            r_valid;

  logic [XLEN-1:0] w_min;
  logic            w_uns;
  logic            w_acc;
  logic            w_bz;
  logic            w_ovf;
  logic            w_hit;
  logic            w_fast;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;
  logic [XLEN-1:0] w_q_fin;
  logic [XLEN-1:0] w_r_fin;
  logic [XLEN-1:0] w_fast_res;

  assign w_min   = {1'b1, {(XLEN-1){1'b0}}};
  assign w_uns   = bus.Funct3[F3_UNS];
  assign w_acc   = bus.Valid_In & bus.IDiv & ~bus.Flush;
  assign w_bz    = bus.Op_B == '0;
  assign w_ovf   = ~w_uns & (bus.Op_A == w_min)
                 & (bus.Op_B == '1);
  assign w_a_neg = ~w_uns & bus.Op_A[XLEN-1];
  assign w_b_neg = ~w_uns & bus.Op_B[XLEN-1];
  assign w_a_abs = w_a_neg ? -bus.Op_A : bus.Op_A;
  assign w_b_abs = w_b_neg ? -bus.Op_B : bus.Op_B;
  assign w_q_fin = r_neg_q ? -r_quo : r_quo;
  assign w_r_fin = r_neg_r ? -r_rem : r_rem;
  assign w_fast  = w_bz | w_ovf | w_hit;

`ifdef DIV_RESULT_CACHE_EN
  logic            r_c_vld;
  logic            r_c_sgn;
  logic            r_sgn;
  logic [XLEN-1:0] r_c_a;
  logic [XLEN-1:0] r_c_b;
  logic [XLEN-1:0] r_c_q;
  logic [XLEN-1:0] r_c_r;
  logic [XLEN-1:0] r_op_a;
  logic [XLEN-1:0] r_op_b;

  assign w_hit = r_c_vld & (r_c_a == bus.Op_A)
               & (r_c_b == bus.Op_B)
               & (r_c_sgn == ~w_uns);

  // Cache holds whatever last reached DONE, special cases included.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_c_vld <= 1'b0;
      r_c_sgn <= 1'b0;
      r_sgn   <= 1'b0;
      r_c_a   <= '0;
      r_c_b   <= '0;
      r_c_q   <= '0;
      r_c_r   <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
    end else if (bus.Flush) begin
      if (r_state == S_CALC || r_state == S_SIGN)
        r_c_vld <= 1'b0;
    end else if (r_state == S_IDLE && w_acc) begin
      r_op_a <= bus.Op_A;
      r_op_b <= bus.Op_B;
      r_sgn  <= ~w_uns;
      if (w_bz | w_ovf) begin
        r_c_vld <= 1'b1;
        r_c_a   <= bus.Op_A;
        r_c_b   <= bus.Op_B;
        r_c_sgn <= ~w_uns;
        r_c_q   <= w_bz ? '1 : w_min;
        r_c_r   <= w_bz ? bus.Op_A : '0;
      end
    end else if (r_state == S_SIGN) begin
      r_c_vld <= 1'b1;
      r_c_a   <= r_op_a;
      r_c_b   <= r_op_b;
      r_c_sgn <= r_sgn;
      r_c_q   <= w_q_fin;
      r_c_r   <= w_r_fin;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_comb begin
    w_fast_res = '0;
    unique case (1'b1)
      w_bz:  w_fast_res = bus.Funct3[F3_REM] ? bus.Op_A : '1;
      w_ovf: w_fast_res = bus.Funct3[F3_REM] ? '0 : w_min;
      default: begin
`ifdef DIV_RESULT_CACHE_EN
        w_fast_res = bus.Funct3[F3_REM] ? r_c_r : r_c_q;
`else
        w_fast_res = '0;
`endif
      end
    endcase
  end

  div_iter_step #(.XLEN(XLEN)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nx),
    .o_quo (w_quo_nx)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_f3_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else if (bus.Flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_busy   <= 1'b1;
            r_f3_rem <= bus.Funct3[F3_REM];
            if (w_fast) begin
              r_res   <= w_fast_res;
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_a_abs;
              r_dvs   <= w_b_abs;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_cnt   <= CNT_W'(XLEN);
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1))
            r_state <= S_SIGN;
        end
        S_SIGN: begin
          r_res   <= r_f3_rem ? w_r_fin : w_q_fin;
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Stall = ((r_state == S_IDLE) & w_acc)
                   | (r_state == S_CALC)
                   | (r_state == S_SIGN);
  assign bus.Busy       = r_busy;
  assign bus.Div_Valid  = r_valid;
  assign bus.Div_Result = r_res;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: reference arithmetic model plus per-cycle compare.
// Latency expectations follow DIV_RESULT_CACHE_EN when it is defined.
module tb_div_seq_ctrl;
  import div_seq_ctrl_pkg::*;

  localparam int XL = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  div_seq_ctrl_if #(.XLEN(XL)) bus ();

  div_seq_ctrl #(.XLEN(XL)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // Reference: RISC-V M semantics from plain arithmetic.
  function automatic logic [31:0] ref_res(input logic [1:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    logic [63:0] q, r;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (f3[0]) return f3[1] ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = 64'(sa / sb);
    r  = 64'(sa % sb);
    return f3[1] ? r[31:0] : q[31:0];
  endfunction

  // Model of the operation currently in flight.
  bit          chk_en = 0;
  bit          m_on   = 0;
  bit          m_done = 0;
  bit          m_kill_rst = 0;
  bit          m_sg   = 0;
  int          m_t0   = 0;
  int          m_end  = 0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_last = '0;
  logic [31:0] m_a    = '0;
  logic [31:0] m_b    = '0;
  bit          c_v    = 0;
  bit          c_s    = 0;
  logic [31:0] c_a    = '0;
  logic [31:0] c_b    = '0;
  bit          e_v, e_b, e_s;

  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (chk_en) begin
        e_v = m_on && m_done && cyc == m_end;
        if (e_v) begin
          m_last = m_res;
          c_v = 1; c_a = m_a; c_b = m_b; c_s = m_sg;
        end
        if (m_on && !m_done && m_kill_rst && cyc == m_end + 1)
          m_last = '0;
        e_b = m_on && cyc > m_t0 && cyc <= m_end;
        e_s = m_on && cyc >= m_t0 &&
              (m_done ? cyc < m_end : cyc <= m_end);
        chk("valid",  32'(bus.Div_Valid), 32'(e_v));
        chk("busy",   32'(bus.Busy),      32'(e_b));
        chk("stall",  32'(bus.Stall),     32'(e_s));
        chk("result", bus.Div_Result,     m_last);
      end
    end
  end

  typedef struct {
    logic [1:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    int          kill;
    bit          krst;
    logic [31:0] lit;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [1:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input int kill,
                     input bit krst, input logic [31:0] lit);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b;
    v.kill = kill; v.krst = krst; v.lit = lit;
    tv.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge where the next op may start.
  task automatic do_op(input vec_t v);
    int lat;
    bit sg, seen;
    logic [31:0] got;
    sg   = !v.f3[0];
    lat  = XL + 2;
    seen = 0;
    got  = '0;
    if (v.b == 0 || (sg && v.a == 32'h8000_0000 && v.b == 32'hFFFF_FFFF))
      lat = 1;
`ifdef DIV_RESULT_CACHE_EN
    if (c_v && c_a == v.a && c_b == v.b && c_s == sg) lat = 1;
`endif
    if (v.kill > 0) c_v = 0;
    bus.Valid_In = 1; bus.IDiv = 1; bus.Funct3 = v.f3;
    bus.Op_A = v.a;   bus.Op_B = v.b;
    m_t0 = cyc; m_res = ref_res(v.f3, v.a, v.b);
    m_a = v.a; m_b = v.b; m_sg = sg; m_kill_rst = v.krst;
    m_done = (v.kill == 0);
    m_end  = cyc + ((v.kill > 0) ? v.kill : lat);
    m_on   = 1;
    for (int k = 1; k <= XL + 4; k++) begin
      @(negedge CLK);
      // Garbage on the bus while busy must be ignored.
      bus.Op_A = ~v.a; bus.Op_B = v.b ^ 32'h5A5A_0001;
      bus.Funct3 = ~v.f3;
      bus.Valid_In = (v.kill == 0) ? (k <= lat) : (k < v.kill);
      bus.IDiv = bus.Valid_In;
      RST = 0; bus.Flush = 0;
      if (v.kill > 0 && k == v.kill) begin
        if (v.krst) RST = 1;
        else bus.Flush = 1;
      end
      #1;
      if (bus.Div_Valid && !seen) begin
        seen = 1;
        got  = bus.Div_Result;
      end
      if (k == ((v.kill > 0) ? v.kill + 2 : lat)) break;
    end
    @(negedge CLK);
    bus.Valid_In = 0; bus.IDiv = 0;
    RST = 0; bus.Flush = 0;
    if (v.kill > 0)
      chk("killed_no_valid", 32'(seen), 32'd0);
    else if (!seen)
      chk("timeout_no_valid", 32'(seen), 32'd1);
    else
      chk("literal", got, v.lit);
  endtask

  initial begin
    bus.Valid_In = 0; bus.IDiv = 0; bus.Funct3 = 2'b00;
    bus.Op_A = '0; bus.Op_B = '0; bus.Flush = 0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_stall", 32'(bus.Stall),     32'd0);
    chk("rst_busy",  32'(bus.Busy),      32'd0);
    chk("rst_valid", 32'(bus.Div_Valid), 32'd0);
    chk("rst_res",   bus.Div_Result,     32'd0);
    RST = 0;
    chk_en = 1;
    @(negedge CLK);

    // f3: 00 DIV, 01 DIVU, 10 REM, 11 REMU
    add(2'b01, 32'd100,        32'd7,          0,  0, 32'd14);
    add(2'b11, 32'd100,        32'd7,          0,  0, 32'd2);
    add(2'b00, 32'hFFFF_FFF9,  32'd2,          0,  0, 32'hFFFF_FFFD);
    add(2'b10, 32'hFFFF_FFF9,  32'd2,          0,  0, 32'hFFFF_FFFF);
    add(2'b00, 32'd5,          32'd0,          0,  0, 32'hFFFF_FFFF);
    add(2'b10, 32'd5,          32'd0,          0,  0, 32'd5);
    add(2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  0,  0, 32'h8000_0000);
    add(2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  0,  0, 32'd0);
    add(2'b01, 32'd1000,       32'd3,          10, 0, 32'd0);
    add(2'b01, 32'd9,          32'd3,          0,  0, 32'd3);
    add(2'b00, 32'd7,          32'hFFFF_FFFE,  0,  0, 32'hFFFF_FFFD);
    add(2'b10, 32'd7,          32'hFFFF_FFFE,  0,  0, 32'd1);
    add(2'b01, 32'hFFFF_FFFF,  32'd1,          0,  0, 32'hFFFF_FFFF);
    add(2'b11, 32'h8000_0000,  32'd3,          0,  0, 32'd2);
    add(2'b00, 32'd12345,      32'd12345,      5,  1, 32'd0);
    add(2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  0,  0, 32'hFFFF_FFFE);
    add(2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  0,  0, 32'd14);
    add(2'b01, 32'd1,          32'h8000_0000,  0,  0, 32'd0);

    foreach (tv[i]) do_op(tv[i]);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
